// File: rtl/store_buffer_pkg.sv
// Shared definitions for the write-posting store buffer: memory geometry,
// default depth and entry field widths.
package store_buf_defs;

    localparam int MEM_WORDS     = 32;
    localparam int ADDR_W        = 5;
    localparam int DATA_W        = 32;
    localparam int DEFAULT_DEPTH = 4;
    localparam int ENTRY_ADDR_W  = ADDR_W;
    localparam int ENTRY_DATA_W  = DATA_W;

    typedef logic [DATA_W-1:0] word_t;

endpackage : store_buf_defs

// File: rtl/store_buffer_match.sv
// Address lookup across all buffer entries; reports a hit and the index of
// the youngest matching valid entry (searched from the tail backwards).
module store_buf_match
    import store_buf_defs::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int AW     = store_buf_defs::ADDR_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [AW-1:0]            i_addr,
    input  logic [DEPTH-1:0][AW-1:0] i_entry_addr,
    input  logic [DEPTH-1:0]         i_valid,
    input  logic [PTR_W-1:0]         i_tail,
    output logic                     o_hit,
    output logic [PTR_W-1:0]         o_idx
);

    // Oldest-to-youngest sweep so the youngest match overrides earlier ones
    always_comb begin
        logic [PTR_W-1:0] v_i;
        v_i   = '0;
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            v_i = i_tail - PTR_W'(k);
            if (i_valid[v_i] && (i_entry_addr[v_i] == i_addr)) begin
                o_hit = 1'b1;
                o_idx = v_i;
            end else begin
                o_hit = o_hit;
                o_idx = o_idx;
            end
        end
    end

endmodule : store_buf_match

// File: rtl/store_buffer.sv
// Write-posting store buffer in front of a single-port data memory.
// Define STORE_BUF_FWD_EN to forward buffered data to loads instead of stalling.
module store_buffer
    import store_buf_defs::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = store_buf_defs::ADDR_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        flush,
    output logic        empty,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]             r_head;
    logic [PTR_W-1:0]             r_tail;
    logic [PTR_W:0]               r_count;
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    word_t                        r_data [DEPTH];

    logic [ADDR_W-1:0] w_lookup;
    logic [DEPTH-1:0]  w_valid;
    logic              w_full;
    logic              w_empty;
    logic              w_hit;
    logic [PTR_W-1:0]  w_hit_idx;
    logic              w_load;
    logic              w_store_stall;
    logic              w_flush_stall;
    logic              w_load_stall;
    logic              w_stall;
    logic              w_load_port;
    logic              w_drain;
    logic              w_push;
    logic              w_unused_addr;

    assign w_lookup      = cpu_addr[ADDR_W-1:0];
    assign w_unused_addr = ^cpu_addr[31:ADDR_W];
    assign w_full        = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_load        = cpu_re & ~cpu_we;

    // Entry i is live when its distance from the head is below the count
    always_comb begin
        logic [PTR_W-1:0] v_off;
        v_off   = '0;
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_off      = PTR_W'(i) - r_head;
            w_valid[i] = ({1'b0, v_off} < r_count);
        end
    end

    store_buf_match #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W),
        .PTR_W (PTR_W)
    ) u_match (
        .i_addr       (w_lookup),
        .i_entry_addr (r_addr),
        .i_valid      (w_valid),
        .i_tail       (r_tail),
        .o_hit        (w_hit),
        .o_idx        (w_hit_idx)
    );

    assign w_store_stall = cpu_we & w_full;
    assign w_flush_stall = flush & ~w_empty;
    assign w_stall       = w_store_stall | w_flush_stall | w_load_stall;
    assign w_load_port   = w_load & ~w_stall;
    assign w_drain       = ~w_load_port & ~w_empty;
    assign w_push        = cpu_we & ~w_full & ~w_flush_stall;

`ifdef STORE_BUF_FWD_EN
    assign w_load_stall = 1'b0;
    assign cpu_rdata    = w_hit ? r_data[w_hit_idx] : mem_rdata;
`else
    // Hit index is only needed for forwarding
    logic w_unused_idx;
    assign w_unused_idx = ^w_hit_idx;
    assign w_load_stall = w_load & w_hit;
    assign cpu_rdata    = mem_rdata;
`endif

    assign cpu_stall = w_stall;
    assign empty     = w_empty;

    // Memory port mux: unstalled load first, otherwise drain the head entry
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        if (w_load_port) begin
            mem_addr = {{(32-ADDR_W){1'b0}}, w_lookup};
        end else if (w_drain) begin
            mem_we    = 1'b1;
            mem_addr  = {{(32-ADDR_W){1'b0}}, r_addr[r_head]};
            mem_wdata = r_data[r_head];
        end else begin
            mem_we    = 1'b0;
            mem_addr  = 32'h0000_0000;
            mem_wdata = 32'h0000_0000;
        end
    end

    // FIFO state: enqueue at tail, dequeue at head, count tracks occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_addr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= 32'h0000_0000;
            end
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= w_lookup;
                r_data[r_tail] <= cpu_wdata;
                r_tail         <= r_tail + PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : store_buffer
